sram_axi_slave: RTL and testbench

- Single-clock AXI4 slave wrapper that sits directly downstream of the interconnect's S1/S2 slave ports and drives one synchronous single-port SRAM macro (IM or DM).
- Converts AR/R and AW/W/B bursts into per-word SRAM accesses.
- Returns IDs extended to the interconnect's slave-side ID width (AXI_IDS_BITS).

---
 rtl/axi_pkg.sv | 24 ++
 rtl/sram_axi_slave.sv | 186 ++++++++++++++++++
 tb/tb_sram_axi_slave.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants and the state type of the SRAM slave wrapper.
package axi_pkg;

    localparam int AXI_ID_BITS   = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 4;
    localparam int AXI_SIZE_BITS = 3;
    localparam int AXI_STRB_BITS = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_FETCH,
        S_R_DATA,
        S_W_DATA,
        S_W_RESP
    } sram_slv_state_e;

endpackage

// File: rtl/sram_axi_slave.sv
// AXI4 slave that turns AR/R and AW/W/B bursts into word accesses on a
// synchronous single-port SRAM macro.
module sram_axi_slave
    import axi_pkg::*;
#(
    parameter int SRAM_AW = 14,
    parameter int DATA_W  = AXI_DATA_BITS,
    parameter int IDS_W   = AXI_IDS_BITS
) (
    input  logic                SRAM_CLK_i,
    input  logic                SRAM_RST_i,
    input  logic [IDS_W-1:0]    ARID_i,
    input  logic [31:0]         ARADDR_i,
    input  logic [3:0]          ARLEN_i,
    input  logic [2:0]          ARSIZE_i,
    input  logic [1:0]          ARBURST_i,
    input  logic                ARVALID_i,
    output logic                ARREADY_o,
    output logic [IDS_W-1:0]    RID_o,
    output logic [DATA_W-1:0]   RDATA_o,
    output logic [1:0]          RRESP_o,
    output logic                RLAST_o,
    output logic                RVALID_o,
    input  logic                RREADY_i,
    input  logic [IDS_W-1:0]    AWID_i,
    input  logic [31:0]         AWADDR_i,
    input  logic [3:0]          AWLEN_i,
    input  logic [2:0]          AWSIZE_i,
    input  logic [1:0]          AWBURST_i,
    input  logic                AWVALID_i,
    output logic                AWREADY_o,
    input  logic [DATA_W-1:0]   WDATA_i,
    input  logic [DATA_W/8-1:0] WSTRB_i,
    input  logic                WLAST_i,
    input  logic                WVALID_i,
    output logic                WREADY_o,
    output logic [IDS_W-1:0]    BID_o,
    output logic [1:0]          BRESP_o,
    output logic                BVALID_o,
    input  logic                BREADY_i,
    output logic                CEB_o,
    output logic                WEB_o,
    output logic [DATA_W-1:0]   BWEB_o,
    output logic [SRAM_AW-1:0]  A_o,
    output logic [DATA_W-1:0]   DI_o,
    input  logic [DATA_W-1:0]   DO_i
);

    sram_slv_state_e    state_reg, state_next;
    logic [IDS_W-1:0]   id_reg, id_next;
    logic [SRAM_AW-1:0] addr_reg, addr_next;
    logic [3:0]         len_reg, len_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic               first_reg, first_next;
    logic [DATA_W-1:0]  rdata_reg;

    logic arready, awready, wready, rvalid, bvalid, rlast;
    logic access, write, run;

    // Size/burst and the address bits outside the SRAM window carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{ARSIZE_i, ARBURST_i, AWSIZE_i, AWBURST_i,
                           ARADDR_i[31:SRAM_AW+2], ARADDR_i[1:0],
                           AWADDR_i[31:SRAM_AW+2], AWADDR_i[1:0]};

    always_ff @(posedge SRAM_CLK_i) begin
        if (SRAM_RST_i) begin
            state_reg <= S_IDLE;
            id_reg    <= '0;
            addr_reg  <= '0;
            len_reg   <= '0;
            cnt_reg   <= '0;
            first_reg <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
            addr_reg  <= addr_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            first_reg <= first_next;
            if (first_reg) begin
                rdata_reg <= DO_i;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        first_next = 1'b0;
        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        rvalid     = 1'b0;
        bvalid     = 1'b0;
        rlast      = 1'b0;
        access     = 1'b0;
        write      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                awready = 1'b1;
                arready = ~AWVALID_i;
                if (AWVALID_i) begin
                    id_next    = AWID_i;
                    addr_next  = AWADDR_i[SRAM_AW+1:2];
                    len_next   = AWLEN_i;
                    cnt_next   = '0;
                    state_next = S_W_DATA;
                end else if (ARVALID_i) begin
                    id_next    = ARID_i;
                    addr_next  = ARADDR_i[SRAM_AW+1:2];
                    len_next   = ARLEN_i;
                    cnt_next   = '0;
                    state_next = S_R_FETCH;
                end
            end
            S_R_FETCH: begin
                access     = 1'b1;
                first_next = 1'b1;
                state_next = S_R_DATA;
            end
            S_R_DATA: begin
                rvalid = 1'b1;
                rlast  = (cnt_reg == len_reg);
                if (RREADY_i) begin
                    if (rlast) begin
                        state_next = S_IDLE;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        cnt_next   = cnt_reg + 4'd1;
                        state_next = S_R_FETCH;
                    end
                end
            end
            S_W_DATA: begin
                wready = 1'b1;
                if (WVALID_i) begin
                    access    = 1'b1;
                    write     = 1'b1;
                    addr_next = addr_reg + 1'b1;
                    cnt_next  = cnt_reg + 4'd1;
                    if (WLAST_i) begin
                        state_next = S_W_RESP;
                    end
                end
            end
            S_W_RESP: begin
                bvalid = 1'b1;
                if (BREADY_i) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // While reset is held nothing handshakes and the macro is left untouched.
    assign run       = ~SRAM_RST_i;
    assign ARREADY_o = arready & run;
    assign AWREADY_o = awready & run;
    assign WREADY_o  = wready & run;
    assign RVALID_o  = rvalid & run;
    assign BVALID_o  = bvalid & run;
    assign RLAST_o   = rlast & run;
    assign RID_o     = id_reg;
    assign BID_o     = id_reg;
    assign RRESP_o   = RESP_OKAY;
    assign BRESP_o   = RESP_OKAY;
    assign CEB_o     = ~(access & run);
    assign WEB_o     = ~(write & run);
    assign A_o       = addr_reg;
    assign DI_o      = (write & run) ? WDATA_i : '0;
    // First R_DATA cycle shows the macro output directly; later cycles hold the capture.
    assign RDATA_o   = first_reg ? DO_i : rdata_reg;

    generate
        for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_bweb
            assign BWEB_o[gi*8 +: 8] = {8{~(write & run & WSTRB_i[gi])}};
        end
    endgenerate

endmodule

// File: tb/tb_sram_axi_slave.sv
// Bench for sram_axi_slave: SRAM macro model on the pins, transaction-level
// memory model, per-cycle monitor against expected queues.
module tb_sram_axi_slave;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        srst;
    logic [7:0]  ARID_i, AWID_i, RID_o, BID_o;
    logic [31:0] ARADDR_i, AWADDR_i, RDATA_o, WDATA_i, BWEB_o, DI_o, DO_i;
    logic [3:0]  ARLEN_i, AWLEN_i, WSTRB_i;
    logic [2:0]  ARSIZE_i, AWSIZE_i;
    logic [1:0]  ARBURST_i, AWBURST_i, RRESP_o, BRESP_o;
    logic        ARVALID_i, ARREADY_o, RLAST_o, RVALID_o, RREADY_i;
    logic        AWVALID_i, AWREADY_o, WLAST_i, WVALID_i, WREADY_o;
    logic        BVALID_o, BREADY_i, CEB_o, WEB_o;
    logic [13:0] A_o;

    always #5 clk = ~clk;

    sram_axi_slave dut (
        .SRAM_CLK_i(clk), .SRAM_RST_i(srst),
        .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARSIZE_i(ARSIZE_i),
        .ARBURST_i(ARBURST_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
        .RID_o(RID_o), .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RLAST_o(RLAST_o),
        .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
        .AWID_i(AWID_i), .AWADDR_i(AWADDR_i), .AWLEN_i(AWLEN_i), .AWSIZE_i(AWSIZE_i),
        .AWBURST_i(AWBURST_i), .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
        .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WLAST_i(WLAST_i), .WVALID_i(WVALID_i),
        .WREADY_o(WREADY_o),
        .BID_o(BID_o), .BRESP_o(BRESP_o), .BVALID_o(BVALID_o), .BREADY_i(BREADY_i),
        .CEB_o(CEB_o), .WEB_o(WEB_o), .BWEB_o(BWEB_o), .A_o(A_o), .DI_o(DI_o), .DO_i(DO_i)
    );

    // SRAM macro behaviour as seen on the pins
    logic [31:0] sram_mem [0:16383];
    logic [31:0] do_q;
    assign DO_i = do_q;
    always @(posedge clk) begin
        if (!CEB_o) begin
            if (!WEB_o) sram_mem[A_o] <= (sram_mem[A_o] & BWEB_o) | (DI_o & ~BWEB_o);
            else        do_q <= sram_mem[A_o];
        end
    end

    typedef struct packed { logic [13:0] a; logic [31:0] d; logic [31:0] m; } wexp_t;
    typedef struct packed { logic [31:0] d; logic [7:0] id; logic last; } rexp_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] ref_mem [logic [13:0]];
    logic [13:0] exp_raddr [$];
    wexp_t       exp_w [$];
    rexp_t       exp_r [$];
    logic [7:0]  exp_b [$];
    logic [13:0] obs_raddr [$];
    logic [31:0] obs_bweb [$];
    logic [31:0] obs_rdata [$];
    logic [7:0]  last_rid;
    logic [31:0] wdata_buf [16];
    logic [3:0]  wstrb_buf [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[k*8 +: 8] = {8{~s[k]}};
        return m;
    endfunction

    // Per-cycle monitor
    wexp_t       mon_w;
    rexp_t       mon_r;
    logic        prev_rv, prev_rr, prev_rlast;
    logic [31:0] prev_rdata;
    logic [7:0]  prev_rid;
    always @(negedge clk) begin
        if (srst) begin
            prev_rv = 1'b0;
            prev_rr = 1'b0;
        end else begin
            if (!CEB_o && WEB_o) begin
                obs_raddr.push_back(A_o);
                chk("read_expected", exp_raddr.size() != 0, 1);
                if (exp_raddr.size() != 0) chk("read_addr", A_o, exp_raddr.pop_front());
            end else if (!CEB_o) begin
                obs_bweb.push_back(BWEB_o);
                chk("write_expected", exp_w.size() != 0, 1);
                if (exp_w.size() != 0) begin
                    mon_w = exp_w.pop_front();
                    chk("write_addr", A_o, mon_w.a);
                    chk("write_data", DI_o, mon_w.d);
                    chk("write_bweb", BWEB_o, mon_w.m);
                end
            end else begin
                chk("sram_idle", {WEB_o, BWEB_o}, {1'b1, 32'hFFFF_FFFF});
            end
            if (prev_rv && !prev_rr) begin
                chk("r_hold_valid", RVALID_o, 1);
                chk("r_hold_beat", {RDATA_o, RID_o, RLAST_o}, {prev_rdata, prev_rid, prev_rlast});
            end
            if (RVALID_o) chk("r_expected", exp_r.size() != 0, 1);
            if (RVALID_o && RREADY_i && exp_r.size() != 0) begin
                mon_r = exp_r.pop_front();
                chk("rdata", RDATA_o, mon_r.d);
                chk("rid", RID_o, mon_r.id);
                chk("rlast", RLAST_o, mon_r.last);
                chk("rresp", RRESP_o, RESP_OKAY);
                obs_rdata.push_back(RDATA_o);
                last_rid = RID_o;
            end
            if (BVALID_o) chk("b_expected", exp_b.size() != 0, 1);
            if (BVALID_o && BREADY_i && exp_b.size() != 0) begin
                chk("bid", BID_o, exp_b.pop_front());
                chk("bresp", BRESP_o, RESP_OKAY);
            end
            prev_rv    = RVALID_o;
            prev_rr    = RREADY_i;
            prev_rdata = RDATA_o;
            prev_rid   = RID_o;
            prev_rlast = RLAST_o;
        end
    end

    task automatic check_reset_values();
        chk("rst_handshake", {ARREADY_o, AWREADY_o, WREADY_o, RVALID_o, BVALID_o, RLAST_o}, 0);
        chk("rst_sram_ctl", {CEB_o, WEB_o, BWEB_o}, {2'b11, 32'hFFFF_FFFF});
        chk("rst_addr_data", {A_o, DI_o}, 0);
        chk("rst_ids_resp", {RID_o, BID_o, RRESP_o, BRESP_o}, 0);
        chk("rst_rdata", RDATA_o, 0);
    endtask

    task automatic aw_handshake(input logic [7:0] id, input logic [31:0] addr, input int len);
        int n;
        AWID_i = id; AWADDR_i = addr; AWLEN_i = 4'(len);
        AWSIZE_i = 3'b010; AWBURST_i = BURST_INCR; AWVALID_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!AWREADY_o && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready_seen", AWREADY_o, 1);
        @(posedge clk); #1;
        AWVALID_i = 1'b0;
        $display("AW id=%02h addr=%08h len=%0d", id, addr, len);
    endtask

    task automatic send_w(input int len, input int gap_max, input int reset_at, input logic [31:0] addr);
        logic [13:0] wa;
        logic [31:0] m, old;
        int n;
        wa = addr[15:2];
        for (int b = 0; b <= len; b++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            WDATA_i = wdata_buf[b]; WSTRB_i = wstrb_buf[b];
            WLAST_i = (b == len); WVALID_i = 1'b1;
            if (b == reset_at) begin
                srst = 1'b1;
                @(posedge clk); #1;
                WVALID_i = 1'b0; WLAST_i = 1'b0;
                @(negedge clk);
                check_reset_values();
                @(posedge clk); #1;
                srst = 1'b0;
                $display("RESET mid-burst at beat %0d", b);
                return;
            end
            m = strb_mask(wstrb_buf[b]);
            exp_w.push_back({wa, wdata_buf[b], m});
            old = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
            ref_mem[wa] = (old & m) | (wdata_buf[b] & ~m);
            n = 0;
            @(negedge clk);
            while (!WREADY_o && n < 50) begin @(negedge clk); n++; end
            chk("w_ready_seen", WREADY_o, 1);
            @(posedge clk); #1;
            WVALID_i = 1'b0; WLAST_i = 1'b0;
            wa = wa + 14'd1;
        end
    endtask

    task automatic collect_b(input logic [7:0] id);
        int n;
        exp_b.push_back(id);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        BREADY_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!BVALID_o && n < 50) begin @(negedge clk); n++; end
        chk("b_valid_seen", BVALID_o, 1);
        @(posedge clk); #1;
        BREADY_i = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input int gap_max, input int reset_at);
        aw_handshake(id, addr, len);
        send_w(len, gap_max, reset_at, addr);
        if (reset_at < 0 || reset_at > len) collect_b(id);
    endtask

    task automatic push_read_exp(input logic [7:0] id, input logic [31:0] addr, input int len);
        logic [13:0] a;
        for (int b = 0; b <= len; b++) begin
            a = addr[15:2] + 14'(b);
            exp_raddr.push_back(a);
            exp_r.push_back({ref_mem[a], id, b == len});
        end
    endtask

    task automatic ar_handshake(input logic [7:0] id, input logic [31:0] addr, input int len);
        int n;
        ARID_i = id; ARADDR_i = addr; ARLEN_i = 4'(len);
        ARSIZE_i = 3'b010; ARBURST_i = BURST_INCR; ARVALID_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ARREADY_o && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready_seen", ARREADY_o, 1);
        @(posedge clk); #1;
        ARVALID_i = 1'b0;
        $display("AR id=%02h addr=%08h len=%0d", id, addr, len);
    endtask

    // Entered one step after the AR handshake edge; each beat must appear two edges later.
    task automatic collect_read(input int len, input int stall_beat, input int stall_cyc, input bit fast);
        int n;
        RREADY_i = fast;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!RVALID_o && n < 50);
            chk("r_valid_seen", RVALID_o, 1);
            chk("r_latency", n, 2);
            if (!fast) begin
                repeat ((b == stall_beat) ? stall_cyc : $urandom_range(0, 2)) @(negedge clk);
                @(posedge clk); #1;
                RREADY_i = 1'b1;
                @(negedge clk);
                @(posedge clk); #1;
                RREADY_i = 1'b0;
            end
        end
        if (fast) begin
            @(posedge clk); #1;
            RREADY_i = 1'b0;
        end
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int stall_beat, input int stall_cyc, input bit fast);
        push_read_exp(id, addr, len);
        ar_handshake(id, addr, len);
        collect_read(len, stall_beat, stall_cyc, fast);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int n, len, off, rl;
        logic [13:0] base;
        logic [31:0] addr;
        logic [7:0]  id;
        srst = 1'b1;
        ARID_i = 0; ARADDR_i = 0; ARLEN_i = 0; ARSIZE_i = 0; ARBURST_i = 0; ARVALID_i = 0;
        AWID_i = 0; AWADDR_i = 0; AWLEN_i = 0; AWSIZE_i = 0; AWBURST_i = 0; AWVALID_i = 0;
        WDATA_i = 0; WSTRB_i = 0; WLAST_i = 0; WVALID_i = 0; RREADY_i = 0; BREADY_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        srst = 1'b0;

        // single read of a preloaded word
        wdata_buf[0] = 32'hDEAD_BEEF; wstrb_buf[0] = 4'hF;
        do_write(8'h01, 32'h0000_0040, 0, 0, -1);
        obs_rdata.delete();
        do_read(8'h15, 32'h0000_0040, 0, -1, 0, 1'b0);
        chk("single_read_data", obs_rdata[0], 32'hDEAD_BEEF);
        chk("single_read_id", last_rid, 8'h15);

        // burst write with a partial strobe on beat 2
        for (int b = 0; b < 4; b++) begin wdata_buf[b] = 32'hAAAA_AAAA; wstrb_buf[b] = 4'hF; end
        do_write(8'h02, 32'h100, 3, 0, -1);
        wdata_buf[0] = 32'h1111_1111; wdata_buf[1] = 32'h2222_2222;
        wdata_buf[2] = 32'h3333_3333; wdata_buf[3] = 32'h4444_4444;
        wstrb_buf[2] = 4'b0011;
        obs_bweb.delete();
        do_write(8'h2A, 32'h100, 3, 1, -1);
        chk("burst_bweb_beat2", obs_bweb[2], 32'hFFFF_0000);
        chk("burst_beats", obs_bweb.size(), 4);
        obs_rdata.delete();
        do_read(8'h2B, 32'h100, 3, -1, 0, 1'b1);
        chk("burst_word0", obs_rdata[0], 32'h1111_1111);
        chk("burst_word2", obs_rdata[2], 32'hAAAA_3333);

        // read backpressure on beat 1
        obs_raddr.delete();
        do_read(8'h33, 32'h100, 2, 1, 5, 1'b0);
        chk("bp_addr0", obs_raddr[0], 14'h040);
        chk("bp_addr2", obs_raddr[2], 14'h042);

        // simultaneous AR and AW in IDLE
        wdata_buf[0] = 32'hCAFE_F00D; wstrb_buf[0] = 4'hF;
        AWID_i = 8'h41; AWADDR_i = 32'h300; AWLEN_i = 0; AWSIZE_i = 3'b010; AWBURST_i = BURST_INCR;
        ARID_i = 8'h42; ARADDR_i = 32'h300; ARLEN_i = 0; ARSIZE_i = 3'b010; ARBURST_i = BURST_INCR;
        AWVALID_i = 1'b1; ARVALID_i = 1'b1;
        @(negedge clk);
        chk("simul_arready", ARREADY_o, 0);
        chk("simul_awready", AWREADY_o, 1);
        @(posedge clk); #1;
        AWVALID_i = 1'b0;
        $display("AW id=41 addr=00000300 len=0 (with AR pending)");
        exp_b.push_back(8'h41);
        send_w(0, 0, -1, 32'h300);
        BREADY_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!BVALID_o && n < 50) begin @(negedge clk); n++; end
        chk("simul_ar_blocked", {BVALID_o, ARREADY_o}, 2'b10);
        @(posedge clk); #1;
        BREADY_i = 1'b0;
        push_read_exp(8'h42, 32'h300, 0);
        @(negedge clk);
        chk("simul_ar_after_b", ARREADY_o, 1);
        @(posedge clk); #1;
        ARVALID_i = 1'b0;
        $display("AR id=42 addr=00000300 len=0");
        collect_read(0, -1, 0, 1'b0);

        // address wrap at the top of the SRAM
        wdata_buf[0] = 32'h5555_5555; wdata_buf[1] = 32'h6666_6666;
        wstrb_buf[0] = 4'hF; wstrb_buf[1] = 4'hF;
        do_write(8'h50, 32'h0005_FFFC, 1, 0, -1);
        obs_raddr.delete(); obs_rdata.delete();
        do_read(8'h51, 32'h0000_FFFC, 1, -1, 0, 1'b1);
        chk("wrap_addr0", obs_raddr[0], 14'h3FFF);
        chk("wrap_addr1", obs_raddr[1], 14'h0000);
        chk("wrap_data1", obs_rdata[1], 32'h6666_6666);

        // reset during beat 2 of a 4-beat write, then normal traffic
        for (int b = 0; b < 4; b++) begin wdata_buf[b] = 32'h7700_0000 + b; wstrb_buf[b] = 4'hF; end
        do_write(8'h77, 32'h200, 3, 0, 2);
        wdata_buf[0] = 32'h8888_8888;
        do_write(8'h78, 32'h200, 0, 0, -1);
        obs_rdata.delete();
        do_read(8'h79, 32'h200, 1, -1, 0, 1'b0);
        chk("post_reset_new", obs_rdata[0], 32'h8888_8888);
        chk("post_reset_kept", obs_rdata[1], 32'h7700_0001);

        // randomized traffic
        for (int it = 0; it < 20; it++) begin
            id   = 8'($urandom);
            base = 14'($urandom_range(0, 16383));
            len  = $urandom_range(0, 15);
            addr = ($urandom & 32'hFFFF_0003) | {16'h0, base, 2'b00};
            for (int b = 0; b <= len; b++) begin wdata_buf[b] = $urandom; wstrb_buf[b] = 4'hF; end
            do_write(id, addr, len, 2, -1);
            for (int b = 0; b <= len; b++) begin
                wdata_buf[b] = $urandom; wstrb_buf[b] = 4'($urandom_range(0, 15));
            end
            do_write(id ^ 8'h5A, addr, len, 2, -1);
            off = $urandom_range(0, len);
            rl  = $urandom_range(0, len - off);
            do_read(8'($urandom), addr + 32'(off * 4), rl, $urandom_range(0, rl),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        chk("queues_drained", exp_w.size() + exp_r.size() + exp_b.size() + exp_raddr.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
